// File: rtl/int_mul_pkg.sv
// Shared helpers for the pipelined integer multiplier: CSA tree sizing,
// level-to-stage placement and parameter bounds.
package int_mul_pkg;

  localparam int WIDTH_MIN  = 4;
  localparam int WIDTH_MAX  = 32;
  localparam int STAGES_MIN = 1;
  localparam int STAGES_MAX = 4;

  // Rows left after applying lvls rounds of 3:2 compression.
  function automatic int rows_after(input int rows, input int lvls);
    int r;
    r = rows;
    for (int i = 0; i < lvls; i++)
      if (r > 2) r = 2 * (r / 3) + r % 3;
    return r;
  endfunction

  function automatic int csa_levels(input int rows);
    int r;
    int n;
    r = rows;
    n = 0;
    for (int i = 0; i < 64; i++)
      if (r > 2) begin
        r = 2 * (r / 3) + r % 3;
        n++;
      end
    return n;
  endfunction

  function automatic int level_stage(input int lvl, input int levels, input int stages);
    return (lvl * stages) / levels;
  endfunction

  // First level owned by a stage; equals levels when stg == stages.
  function automatic int stage_first_level(input int stg, input int levels, input int stages);
    return (stg * levels + stages - 1) / stages;
  endfunction

endpackage

// File: rtl/csa_compressor3.sv
// Bitwise 3:2 compressor; carry is returned unshifted.
module csa_compressor3 #(
  parameter int W = 8
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic [W-1:0] z,
  output logic [W-1:0] sum,
  output logic [W-1:0] carry
);

  assign sum   = x ^ y ^ z;
  assign carry = (x & y) | (x & z) | (y & z);

endmodule

// File: rtl/pipelined_int_multiplier.sv
// Pipelined unsigned multiplier: CSA tree spread over STAGES register banks, CPA in the last.
// Define INT_MUL_STICKY_EN to add the registered out_sticky output.
module pipelined_int_multiplier
  import int_mul_pkg::*;
#(
  parameter int WIDTH  = 24,
  parameter int STAGES = 3,
  parameter int TAG_W  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDTH-1:0]              in_a,
  input  logic [WIDTH-1:0]              in_b,
  input  logic [TAG_W-1:0]              in_tag,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [2*WIDTH-1:0]            out_product,
  output logic [TAG_W-1:0]              out_tag,
`ifdef INT_MUL_STICKY_EN
  output logic                          out_sticky,
`endif
  output logic [$clog2(STAGES+1)-1:0]   occupancy
);

  localparam int PW     = 2 * WIDTH;
  localparam int LEVELS = csa_levels(WIDTH);
  localparam int OCW    = $clog2(STAGES + 1);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX || STAGES < STAGES_MIN ||
      STAGES > STAGES_MAX || TAG_W < 1) begin : g_bad_param
    $error("pipelined_int_multiplier: parameter out of range");
  end

  logic                         w_advance;
  logic                         w_acc;
  logic [WIDTH-1:0]             w_a;
  logic [WIDTH-1:0]             w_b;
  logic [PW-1:0]                w_pp [WIDTH];
  logic [PW-1:0]                w_product;
  logic [PW-1:0]                r_product;
  logic [STAGES:1]              r_vld_pipe;
  logic [STAGES:1]              w_vld_nxt;
  logic [STAGES:1][TAG_W-1:0]   r_tag_pipe;
  logic [OCW-1:0]               r_occ;
  logic [OCW-1:0]               w_occ_nxt;

  assign w_advance = !r_vld_pipe[STAGES] || out_ready;
  assign in_ready  = w_advance;
  assign w_acc     = in_valid && w_advance;
  // Bubbles carry zero operands so idle stages never pick up stray input data.
  assign w_a       = w_acc ? in_a : '0;
  assign w_b       = w_acc ? in_b : '0;

  always_comb begin
    for (int i = 0; i < WIDTH; i++)
      w_pp[i] = PW'(w_a & {WIDTH{w_b[i]}}) << i;
  end

  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    localparam int N   = rows_after(WIDTH, l);
    localparam int NG  = N / 3;
    localparam int NO  = rows_after(WIDTH, l + 1);
    localparam int STG = level_stage(l, LEVELS, STAGES);

    logic [PW-1:0] w_in  [N];
    logic [PW-1:0] w_out [NO];
    logic [PW-2:0] w_s   [NG];
    logic [PW-2:0] w_c   [NG];

    if (l == stage_first_level(STG, LEVELS, STAGES)) begin : g_from_stg
      assign w_in = g_stg[STG].w_in;
    end else begin : g_from_lvl
      assign w_in = g_lvl[(l > 0) ? l - 1 : 0].w_out;
    end

    // The carry out of the MSB would be shifted away, so the compressors cover
    // PW-1 bits and only the top sum bit is formed separately.
    for (genvar g = 0; g < NG; g++) begin : g_csa
      csa_compressor3 #(.W(PW - 1)) u_csa (
        .x    (w_in[3*g][PW-2:0]),
        .y    (w_in[3*g+1][PW-2:0]),
        .z    (w_in[3*g+2][PW-2:0]),
        .sum  (w_s[g]),
        .carry(w_c[g])
      );
    end

    always_comb begin
      for (int g = 0; g < NG; g++) begin
        w_out[2*g]   = {w_in[3*g][PW-1] ^ w_in[3*g+1][PW-1] ^ w_in[3*g+2][PW-1], w_s[g]};
        w_out[2*g+1] = {w_c[g], 1'b0};
      end
      for (int k = 0; k < N - 3 * NG; k++)
        w_out[2*NG+k] = w_in[3*NG+k];
    end
  end

  for (genvar s = 0; s < STAGES; s++) begin : g_stg
    localparam int FL = stage_first_level(s, LEVELS, STAGES);
    localparam int FN = stage_first_level(s + 1, LEVELS, STAGES);
    localparam int NI = rows_after(WIDTH, FL);
    localparam int NO = rows_after(WIDTH, FN);

    logic [PW-1:0] w_in  [NI];
    logic [PW-1:0] w_out [NO];

    if (s == 0) begin : g_in_pp
      assign w_in = w_pp;
    end else begin : g_in_bank
      assign w_in = g_stg[(s > 0) ? s - 1 : 0].g_bank.r_bank;
    end

    if (FN == FL) begin : g_pass
      assign w_out = w_in;
    end else begin : g_tree
      assign w_out = g_lvl[(FN > 0) ? FN - 1 : 0].w_out;
    end

    if (s < STAGES - 1) begin : g_bank
      logic [PW-1:0] r_bank [NO];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         r_bank <= '{default: '0};
        else if (w_advance) r_bank <= w_out;
      end
    end else begin : g_cpa
      assign w_product = w_out[0] + w_out[1];
    end
  end

  always_comb begin
    w_vld_nxt = r_vld_pipe;
    if (w_advance) begin
      w_vld_nxt[1] = w_acc;
      for (int k = 2; k <= STAGES; k++) w_vld_nxt[k] = r_vld_pipe[k-1];
    end
  end

  always_comb begin
    w_occ_nxt = '0;
    for (int k = 1; k <= STAGES; k++) w_occ_nxt = w_occ_nxt + OCW'(w_vld_nxt[k]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_pipe <= '0;
      r_occ      <= '0;
    end else begin
      r_vld_pipe <= w_vld_nxt;
      r_occ      <= w_occ_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag_pipe <= '0;
      r_product  <= '0;
    end else if (w_advance) begin
      r_tag_pipe[1] <= w_acc ? in_tag : '0;
      for (int k = 2; k <= STAGES; k++) r_tag_pipe[k] <= r_tag_pipe[k-1];
      r_product <= w_product;
    end
  end

`ifdef INT_MUL_STICKY_EN
  logic r_sticky;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_sticky <= 1'b0;
    else if (w_advance) r_sticky <= |w_product[WIDTH-3:0];
  end
  assign out_sticky = r_sticky;
`endif

  assign out_valid   = r_vld_pipe[STAGES];
  assign out_product = r_product;
  assign out_tag     = r_tag_pipe[STAGES];
  assign occupancy   = r_occ;

endmodule

// File: tb/tb_pipelined_int_multiplier.sv
// Bench: directed timing/backpressure/reset checks on the default build plus a
// random scoreboard sweep over WIDTH 8/24 and STAGES 1..4.
module tb_pipelined_int_multiplier;

  typedef struct packed {
    logic [63:0] p;
    logic [3:0]  t;
    logic        s;
  } exp_t;

  localparam logic [63:0] M_MSK = (64'd1 << 22) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, s_rst_n;
  int   n_chk = 0;
  int   n_fail = 0;
  int   sw_done = 0;

  logic        m_in_valid, m_in_ready, m_out_valid, m_out_ready;
  logic [23:0] m_in_a, m_in_b;
  logic [3:0]  m_in_tag, m_out_tag;
  logic [47:0] m_out_product;
  logic [1:0]  m_occupancy;
`ifdef INT_MUL_STICKY_EN
  logic        m_out_sticky;
`endif

  exp_t mq[$];

  pipelined_int_multiplier #(.WIDTH(24), .STAGES(3), .TAG_W(4)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (m_in_valid),
    .in_ready   (m_in_ready),
    .in_a       (m_in_a),
    .in_b       (m_in_b),
    .in_tag     (m_in_tag),
    .out_valid  (m_out_valid),
    .out_ready  (m_out_ready),
    .out_product(m_out_product),
    .out_tag    (m_out_tag),
`ifdef INT_MUL_STICKY_EN
    .out_sticky (m_out_sticky),
`endif
    .occupancy  (m_occupancy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One cycle on the main DUT: drive at negedge, then score the transfers of this cycle.
  task automatic step(input logic v, input logic [23:0] a, input logic [23:0] b,
                      input logic [3:0] t, input logic r);
    exp_t e;
    @(negedge clk);
    m_in_valid = v; m_in_a = a; m_in_b = b; m_in_tag = t; m_out_ready = r;
    #1;
    chk("m_occ", 64'(m_occupancy), 64'(mq.size()));
    if (m_out_valid && m_out_ready) begin
      chk("m_sb_nonempty", 64'(mq.size() != 0), 64'd1);
      if (mq.size() != 0) begin
        e = mq.pop_front();
        chk("m_prod", 64'(m_out_product), e.p);
        chk("m_tag", 64'(m_out_tag), 64'(e.t));
`ifdef INT_MUL_STICKY_EN
        chk("m_sticky", 64'(m_out_sticky), 64'(e.s));
`endif
      end
    end
    if (v && m_in_ready) begin
      e.p = 64'(a) * 64'(b);
      e.t = t;
      e.s = |(e.p & M_MSK);
      mq.push_back(e);
    end
  endtask

  task automatic idle();
    step(1'b0, 24'h0, 24'h0, 4'h0, 1'b1);
  endtask

  // Random sweep over other configurations, each with its own scoreboard.
  for (genvar g = 0; g < 8; g++) begin : g_sw
    localparam int W = (g < 4) ? 8 : 24;
    localparam int S = g % 4 + 1;
    localparam logic [63:0] MSK = (64'd1 << (W - 2)) - 1;

    logic                     iv, ir, ov, ordy;
    logic [W-1:0]             a, b;
    logic [3:0]               it, ot;
    logic [2*W-1:0]           p;
    logic [$clog2(S+1)-1:0]   occ;
`ifdef INT_MUL_STICKY_EN
    logic                     st;
`endif

    pipelined_int_multiplier #(.WIDTH(W), .STAGES(S), .TAG_W(4)) u_sw (
      .clk        (clk),
      .rst_n      (s_rst_n),
      .in_valid   (iv),
      .in_ready   (ir),
      .in_a       (a),
      .in_b       (b),
      .in_tag     (it),
      .out_valid  (ov),
      .out_ready  (ordy),
      .out_product(p),
      .out_tag    (ot),
`ifdef INT_MUL_STICKY_EN
      .out_sticky (st),
`endif
      .occupancy  (occ)
    );

    function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 5))
        0:       return '0;
        1:       return '1;
        default: return W'($urandom);
      endcase
    endfunction

    initial begin
      exp_t q[$];
      exp_t e;
      iv = 1'b0; ordy = 1'b0; a = '0; b = '0; it = '0;
      wait (s_rst_n === 1'b1);
      for (int c = 0; c < 400; c++) begin
        @(negedge clk);
        iv   = (c < 380) && ($urandom_range(0, 3) != 0);
        ordy = (c >= 380) || ($urandom_range(0, 3) != 0);
        a    = pick();
        b    = pick();
        it   = 4'($urandom);
        #1;
        chk($sformatf("sw%0d_occ", g), 64'(occ), 64'(q.size()));
        if (ov && ordy) begin
          chk($sformatf("sw%0d_nonempty", g), 64'(q.size() != 0), 64'd1);
          if (q.size() != 0) begin
            e = q.pop_front();
            chk($sformatf("sw%0d_prod", g), 64'(p), e.p);
            chk($sformatf("sw%0d_tag", g), 64'(ot), 64'(e.t));
`ifdef INT_MUL_STICKY_EN
            chk($sformatf("sw%0d_sticky", g), 64'(st), 64'(e.s));
`endif
          end
        end
        if (iv && ir) begin
          e.p = 64'(a) * 64'(b);
          e.t = it;
          e.s = |(e.p & MSK);
          q.push_back(e);
        end
      end
      chk($sformatf("sw%0d_drain", g), 64'(q.size()), 64'd0);
      sw_done = sw_done + 1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; s_rst_n = 1'b0;
    m_in_valid = 1'b0; m_in_a = '0; m_in_b = '0; m_in_tag = '0; m_out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", 64'(m_out_valid), 64'd0);
    chk("rst_product", 64'(m_out_product), 64'd0);
    chk("rst_tag", 64'(m_out_tag), 64'd0);
    chk("rst_occ", 64'(m_occupancy), 64'd0);
`ifdef INT_MUL_STICKY_EN
    chk("rst_sticky", 64'(m_out_sticky), 64'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1; s_rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 64'(m_in_ready), 64'd1);

    // Latency: result appears exactly three cycles after the accept cycle.
    step(1'b1, 24'hFFFFFF, 24'hFFFFFF, 4'd5, 1'b1);
    idle(); chk("lat_c1_valid", 64'(m_out_valid), 64'd0);
    idle(); chk("lat_c2_valid", 64'(m_out_valid), 64'd0);
    idle(); chk("lat_c3_valid", 64'(m_out_valid), 64'd1);
    chk("lat_product", 64'(m_out_product), 64'hFFFFFE000001);
    chk("lat_tag", 64'(m_out_tag), 64'd5);

    // Back-to-back stream, including zero operands.
    step(1'b1, 24'd3, 24'd7, 4'd1, 1'b1);
    step(1'b1, 24'h123456, 24'h10, 4'd2, 1'b1);
    step(1'b1, 24'h0, 24'hABCDEF, 4'd3, 1'b1);
    idle(); chk("str0_prod", 64'(m_out_product), 64'd21);        chk("str0_tag", 64'(m_out_tag), 64'd1);
    idle(); chk("str1_prod", 64'(m_out_product), 64'h1234560);   chk("str1_tag", 64'(m_out_tag), 64'd2);
    idle(); chk("str2_prod", 64'(m_out_product), 64'd0);         chk("str2_tag", 64'(m_out_tag), 64'd3);
    chk("str2_valid", 64'(m_out_valid), 64'd1);

    // Backpressure: fill with out_ready low, then stream through a full pipe.
    for (int i = 0; i < 3; i++) step(1'b1, 24'($urandom), 24'($urandom), 4'(i + 10), 1'b0);
    step(1'b1, 24'hDEAD00, 24'hBEEF00, 4'd9, 1'b0);
    chk("bp_occ_full", 64'(m_occupancy), 64'd3);
    chk("bp_in_ready", 64'(m_in_ready), 64'd0);
    chk("bp_valid", 64'(m_out_valid), 64'd1);
    chk("bp_hold_prod0", 64'(m_out_product), mq[0].p);
    step(1'b1, 24'h00FF00, 24'h777777, 4'd8, 1'b0);
    chk("bp_hold_prod1", 64'(m_out_product), mq[0].p);
    chk("bp_hold_tag", 64'(m_out_tag), 64'(mq[0].t));
    chk("bp_hold_occ", 64'(m_occupancy), 64'd3);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 24'($urandom), 24'($urandom), 4'(i + 4), 1'b1);
      chk("bp_flow_ready", 64'(m_in_ready), 64'd1);
      chk("bp_flow_occ", 64'(m_occupancy), 64'd3);
    end
    repeat (4) idle();

    // Sticky corner operands.
    step(1'b1, 24'h800000, 24'h800000, 4'd6, 1'b1);
    step(1'b1, 24'h800001, 24'h800001, 4'd7, 1'b1);
    idle();
    idle(); chk("stk0_prod", 64'(m_out_product), 64'h400000000000);
`ifdef INT_MUL_STICKY_EN
    chk("stk0_sticky", 64'(m_out_sticky), 64'd0);
`endif
    idle(); chk("stk1_prod", 64'(m_out_product), 64'h400001000001);
`ifdef INT_MUL_STICKY_EN
    chk("stk1_sticky", 64'(m_out_sticky), 64'd1);
`endif
    repeat (2) idle();

    // Asynchronous reset with two operations in flight.
    step(1'b1, 24'h111111, 24'h222222, 4'd1, 1'b1);
    step(1'b1, 24'h333333, 24'h444444, 4'd2, 1'b1);
    @(negedge clk);
    m_in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(m_out_valid), 64'd0);
    chk("mid_rst_prod", 64'(m_out_product), 64'd0);
    chk("mid_rst_tag", 64'(m_out_tag), 64'd0);
    chk("mid_rst_occ", 64'(m_occupancy), 64'd0);
    mq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      idle();
      chk("post_rst_valid", 64'(m_out_valid), 64'd0);
    end

    // Random traffic on the main instance.
    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 3) != 0, 24'($urandom), 24'($urandom), 4'($urandom),
           $urandom_range(0, 3) != 0);
    repeat (5) idle();
    chk("main_drain", 64'(mq.size()), 64'd0);

    for (int i = 0; i < 3000 && sw_done < 8; i++) @(negedge clk);
    chk("sweep_done", 64'(sw_done), 64'd8);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
